wb_writer: RTL and testbench

- Writeback-side initiator for the register file write port.
- Accepts results from two producers, the ALU and the load unit, over valid/ready channels and arbitrates between them round-robin.
- Drives the rf port signals we, w_addr and w_data from registers.
- Holds a per-register pending scoreboard so decode can stall while a read operand still has an uncommitted writer.

---
 rtl/wb_writer.sv | 105 ++++++++++
 tb/tb_wb_writer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_writer.sv
// rtl/wb_writer.sv - writeback arbiter, rf write port driver and pending-write scoreboard
// Optional feature macro: WB_FWD_EN (same-cycle forwarding of the committing write)
module wb_writer #(
  parameter int D_WIDTH = 32,
  parameter int N_REGS  = 32,
  parameter int REG_L2  = $clog2(N_REGS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               alu_valid,
  output logic               alu_ready,
  input  logic [REG_L2-1:0]  alu_rd,
  input  logic [D_WIDTH-1:0] alu_data,
  input  logic               ld_valid,
  output logic               ld_ready,
  input  logic [REG_L2-1:0]  ld_rd,
  input  logic [D_WIDTH-1:0] ld_data,
  input  logic               iss_valid,
  input  logic [REG_L2-1:0]  iss_rd,
  input  logic [REG_L2-1:0]  q_rs1,
  input  logic [REG_L2-1:0]  q_rs2,
  output logic               rs1_busy,
  output logic               rs2_busy,
  output logic               we,
  output logic [REG_L2-1:0]  w_addr,
  output logic [D_WIDTH-1:0] w_data
`ifdef WB_FWD_EN
  ,
  output logic               rs1_fwd,
  output logic               rs2_fwd,
  output logic [D_WIDTH-1:0] fwd_data
`endif
);

  logic               prefer_ld;
  logic               gnt_alu;
  logic               gnt_ld;
  logic               hs;
  logic [REG_L2-1:0]  sel_rd;
  logic [D_WIDTH-1:0] sel_data;
  logic [N_REGS-1:0]  pend;
  logic [N_REGS-1:0]  pend_nxt;
  logic               rs1_pend;
  logic               rs2_pend;

  // On a tie the source that lost the previous handshake wins.
  always_comb begin
    gnt_alu = 1'b0;
    gnt_ld  = 1'b0;
    if (alu_valid && ld_valid) begin
      if (prefer_ld) gnt_ld = 1'b1;
      else           gnt_alu = 1'b1;
    end else if (alu_valid) begin
      gnt_alu = 1'b1;
    end else if (ld_valid) begin
      gnt_ld = 1'b1;
    end
  end

  assign alu_ready = gnt_alu & rst;
  assign ld_ready  = gnt_ld & rst;
  assign hs        = (alu_valid & alu_ready) | (ld_valid & ld_ready);
  assign sel_rd    = gnt_ld ? ld_rd : alu_rd;
  assign sel_data  = gnt_ld ? ld_data : alu_data;

  // Set is applied after clear so a newer in-flight writer keeps the bit.
  always_comb begin
    pend_nxt = pend;
    if (we) pend_nxt[w_addr] = 1'b0;
    if (iss_valid && (iss_rd != '0)) pend_nxt[iss_rd] = 1'b1;
  end

  assign rs1_pend = pend[q_rs1] & (q_rs1 != '0);
  assign rs2_pend = pend[q_rs2] & (q_rs2 != '0);

`ifdef WB_FWD_EN
  assign rs1_fwd  = we & (w_addr == q_rs1) & (q_rs1 != '0);
  assign rs2_fwd  = we & (w_addr == q_rs2) & (q_rs2 != '0);
  assign fwd_data = w_data;
  assign rs1_busy = rs1_pend & ~rs1_fwd;
  assign rs2_busy = rs2_pend & ~rs2_fwd;
`else
  assign rs1_busy = rs1_pend;
  assign rs2_busy = rs2_pend;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we        <= 1'b0;
      w_addr    <= '0;
      w_data    <= '0;
      pend      <= '0;
      prefer_ld <= 1'b1;
    end else begin
      pend <= pend_nxt;
      we   <= hs && (sel_rd != '0);
      if (hs && (sel_rd != '0)) begin
        w_addr <= sel_rd;
        w_data <= sel_data;
      end
      if (hs) prefer_ld <= gnt_alu;
    end
  end

endmodule

// File: tb/tb_wb_writer.sv
// tb/tb_wb_writer.sv - scoreboard bench for wb_writer
module tb_wb_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, alu_ready, ld_valid, ld_ready;
  logic [4:0]  alu_rd, ld_rd, iss_rd, q_rs1, q_rs2, w_addr;
  logic [31:0] alu_data, ld_data, w_data;
  logic        iss_valid, rs1_busy, rs2_busy, we;
`ifdef WB_FWD_EN
  logic        rs1_fwd, rs2_fwd;
  logic [31:0] fwd_data;
`endif

  always #5 clk = ~clk;

  wb_writer dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .q_rs1(q_rs1), .q_rs2(q_rs2),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .we(we), .w_addr(w_addr), .w_data(w_data)
`ifdef WB_FWD_EN
    , .rs1_fwd(rs1_fwd), .rs2_fwd(rs2_fwd), .fwd_data(fwd_data)
`endif
  );

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t expq[$];
  int  total  = 0;
  int  passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, required %h", name, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic push(input logic [4:0] a, input logic [31:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    expq.push_back(e);
  endtask

  // Monitor: every rf write must match the oldest expected write.
  always @(negedge clk) begin
    wr_t e;
    if (rst === 1'b1 && we === 1'b1) begin
      if (expq.size() == 0) begin
        total++;
        $display("FAIL unexpected_write: got addr %0d data %h, required no write", w_addr, w_data);
      end else begin
        e = expq.pop_front();
        chk("w_addr", {27'd0, w_addr}, {27'd0, e.a});
        chk("w_data", w_data, e.d);
      end
    end
  end

  initial begin
    int ai, li;
    rst = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'd0;
    ld_valid = 1'b0; ld_rd = 5'd0; ld_data = 32'd0;
    iss_valid = 1'b0; iss_rd = 5'd0; q_rs1 = 5'd5; q_rs2 = 5'd0;

    // Reset held for three cycles with ALU offering
    repeat (3) @(posedge clk);
    mid();
    chk("rst_we", {31'd0, we}, 32'd0);
    chk("rst_alu_ready", {31'd0, alu_ready}, 32'd0);
    chk("rst_rs1_busy", {31'd0, rs1_busy}, 32'd0);
    chk("rst_w_addr", {27'd0, w_addr}, 32'd0);
    chk("rst_w_data", w_data, 32'd0);
    cyc(); rst = 1'b1;
    mid();
    chk("rel_alu_ready", {31'd0, alu_ready}, 32'd1);
    chk("rel_ld_ready", {31'd0, ld_ready}, 32'd0);
    cyc(); alu_valid = 1'b0;

    // Single write to r7
    iss_valid = 1'b1; iss_rd = 5'd7; q_rs1 = 5'd7;
    mid();
    chk("pre_issue_busy", {31'd0, rs1_busy}, 32'd0);
    cyc(); iss_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'hDEADBEEF;
    push(5'd7, 32'hDEADBEEF);
    mid();
    chk("single_alu_ready", {31'd0, alu_ready}, 32'd1);
    chk("single_busy_pend", {31'd0, rs1_busy}, 32'd1);
    cyc(); alu_valid = 1'b0;
    mid();
    chk("single_we", {31'd0, we}, 32'd1);
    chk("single_busy_commit", {31'd0, rs1_busy}, 32'd1);
    cyc();
    mid();
    chk("single_busy_after", {31'd0, rs1_busy}, 32'd0);
    chk("single_we_after", {31'd0, we}, 32'd0);

    // Contention: tie starts with ld, then alternates; sources hold until accepted
    ai = 1; li = 1;
    for (int k = 0; k < 8; k++) begin
      cyc();
      alu_valid = (ai <= 4); ld_valid = (li <= 4);
      alu_rd = 5'(ai); alu_data = 32'hA000_0000 | ai;
      ld_rd = 5'(li);  ld_data  = 32'hB000_0000 | li;
      mid();
      if (k % 2 == 0) begin
        chk("cont_ld_ready", {31'd0, ld_ready}, 32'd1);
        chk("cont_alu_ready", {31'd0, alu_ready}, 32'd0);
        push(5'(li), 32'hB000_0000 | li);
        li++;
      end else begin
        chk("cont_alu_ready", {31'd0, alu_ready}, 32'd1);
        chk("cont_ld_ready", {31'd0, ld_ready}, 32'd0);
        push(5'(ai), 32'hA000_0000 | ai);
        ai++;
      end
    end
    cyc(); alu_valid = 1'b0; ld_valid = 1'b0;
    mid();

    // Register 0: accepted, no write, pointer advances
    cyc(); ld_valid = 1'b1; ld_rd = 5'd0; ld_data = 32'h1234;
    mid();
    chk("r0_ld_ready", {31'd0, ld_ready}, 32'd1);
    cyc(); ld_rd = 5'd11; ld_data = 32'hB00B;
    alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'hA00A;
    mid();
    chk("r0_no_we", {31'd0, we}, 32'd0);
    chk("r0_tie_alu", {31'd0, alu_ready}, 32'd1);
    chk("r0_tie_ld", {31'd0, ld_ready}, 32'd0);
    push(5'd10, 32'hA00A);
    cyc(); alu_valid = 1'b0;
    mid();
    chk("r0_ld_after", {31'd0, ld_ready}, 32'd1);
    push(5'd11, 32'hB00B);
    cyc(); ld_valid = 1'b0; iss_valid = 1'b1; iss_rd = 5'd0; q_rs1 = 5'd0;
    mid();
    cyc(); iss_valid = 1'b0;
    mid();
    chk("r0_busy", {31'd0, rs1_busy}, 32'd0);

    // Set/clear collision on r3
    cyc(); iss_valid = 1'b1; iss_rd = 5'd3; q_rs2 = 5'd3;
    mid();
    cyc(); iss_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h33;
    push(5'd3, 32'h33);
    mid();
    chk("coll_busy_pend", {31'd0, rs2_busy}, 32'd1);
    cyc(); alu_valid = 1'b0; iss_valid = 1'b1; iss_rd = 5'd3;
    mid();
    chk("coll_we", {31'd0, we}, 32'd1);
    cyc(); iss_valid = 1'b0;
    mid();
    chk("coll_set_wins", {31'd0, rs2_busy}, 32'd1);
    cyc(); alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h34;
    push(5'd3, 32'h34);
    mid();
    cyc(); alu_valid = 1'b0;
    mid();
    cyc();
    mid();
    chk("coll_cleared", {31'd0, rs2_busy}, 32'd0);

    // Commit cycle of r9 while decode reads r9
    cyc(); iss_valid = 1'b1; iss_rd = 5'd9; q_rs1 = 5'd9;
    mid();
    cyc(); iss_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h55;
    push(5'd9, 32'h55);
    mid();
    cyc(); alu_valid = 1'b0;
    mid();
`ifdef WB_FWD_EN
    chk("fwd_rs1_fwd", {31'd0, rs1_fwd}, 32'd1);
    chk("fwd_data", fwd_data, 32'h55);
    chk("fwd_rs1_busy", {31'd0, rs1_busy}, 32'd0);
    chk("fwd_rs2_fwd", {31'd0, rs2_fwd}, 32'd0);
`else
    chk("commit_rs1_busy", {31'd0, rs1_busy}, 32'd1);
`endif
    cyc();
    mid();

    // Reset during an in-flight write
    cyc(); iss_valid = 1'b1; iss_rd = 5'd12; q_rs1 = 5'd12;
    mid();
    cyc(); iss_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd12; alu_data = 32'hC;
    mid();
    chk("mid_busy_pend", {31'd0, rs1_busy}, 32'd1);
    cyc(); alu_valid = 1'b0; rst = 1'b0;
    #1;
    chk("mid_rst_we", {31'd0, we}, 32'd0);
    chk("mid_rst_busy", {31'd0, rs1_busy}, 32'd0);
    mid();
    cyc(); rst = 1'b1;
    mid();
    chk("post_rst_we", {31'd0, we}, 32'd0);
    chk("post_rst_busy", {31'd0, rs1_busy}, 32'd0);

    cyc();
    mid();
    chk("queue_empty", expq.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
